// File: rtl/top_pkg.sv
// Shared definitions for the CSI frame monitor: FSM states, default frame geometry
// and a saturating 8-bit increment helper.
package top_pkg;

    localparam int VSCREEN  = 480;
    localparam int HSCREEN  = 640;
    localparam int NUM_LANE = 2;

    localparam int DEF_EXP_LINES = VSCREEN;
    localparam int DEF_EXP_WORDS = HSCREEN / NUM_LANE;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2,
        ST_LINE  = 2'd3
    } mon_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] value, input logic inc);
        if (inc && (value != 8'hFF)) begin
            return value + 8'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/csi_edge_det.sv
// Single-input edge detector: registers the input once and compares against the
// previous registered value to produce rise/fall strobes and the registered level.
module csi_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise,
    output logic fall,
    output logic level
);

    logic cur_r;
    logic prev_r;

    // Sample history; reset preloads both stages so releasing reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_r  <= sig;
            prev_r <= sig;
        end else begin
            cur_r  <= sig;
            prev_r <= cur_r;
        end
    end

    assign rise  = cur_r & ~prev_r;
    assign fall  = ~cur_r & prev_r;
    assign level = cur_r;

endmodule

// File: rtl/csi_frame_monitor.sv
// CSI-2 receive frame/line geometry monitor with sticky error flags.
// Optional frames-per-second measurement is enabled with FRAME_MON_FPS_EN.
module csi_frame_monitor
    import top_pkg::*;
#(
    parameter int EXP_LINES = DEF_EXP_LINES,
    parameter int EXP_WORDS = DEF_EXP_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             csi_in_frame,
    input  logic             csi_in_line,
    input  logic             csi_word_valid,
    input  logic             sec_tick,
    input  logic             err_clr,
    output logic [CNT_W-1:0] last_lines,
    output logic [CNT_W-1:0] last_words,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       fps,
    output logic             frame_done,
    output logic             err_lines,
    output logic             err_words,
    output logic             err_proto
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO    = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t CNT_MAX     = {CNT_W{1'b1}};
    localparam cnt_t EXP_LINES_C = cnt_t'(EXP_LINES);
    localparam cnt_t EXP_WORDS_C = cnt_t'(EXP_WORDS);

    function automatic cnt_t sat_inc(input cnt_t value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    logic frame_rise_s, frame_fall_s, frame_lvl_s;
    logic line_rise_s, line_fall_s, line_lvl_unused_s;
    logic valid_rise_unused_s, valid_fall_unused_s, valid_lvl_s;

    csi_edge_det u_frame_det (
        .clk(clk), .reset_n(reset_n), .sig(csi_in_frame),
        .rise(frame_rise_s), .fall(frame_fall_s), .level(frame_lvl_s)
    );

    csi_edge_det u_line_det (
        .clk(clk), .reset_n(reset_n), .sig(csi_in_line),
        .rise(line_rise_s), .fall(line_fall_s), .level(line_lvl_unused_s)
    );

    csi_edge_det u_valid_det (
        .clk(clk), .reset_n(reset_n), .sig(csi_word_valid),
        .rise(valid_rise_unused_s), .fall(valid_fall_unused_s), .level(valid_lvl_s)
    );

    mon_state_e state_r, state_n_s;
    logic frame_open_s, line_start_s, beat_s, close_line_s, close_frame_s, proto_err_s;
    logic words_bad_s, lines_bad_s;

    cnt_t line_cnt_r, word_cnt_r;
    cnt_t last_lines_r, last_words_r, frame_cnt_r;
    logic frame_done_r, err_lines_r, err_words_r, err_proto_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next state and per-cycle event strobes; a frame fall in LINE closes both line and frame.
    always_comb begin
        state_n_s     = state_r;
        frame_open_s  = 1'b0;
        line_start_s  = 1'b0;
        beat_s        = 1'b0;
        close_line_s  = 1'b0;
        close_frame_s = 1'b0;
        proto_err_s   = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (!frame_lvl_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                proto_err_s = line_rise_s;
                if (frame_rise_s) begin
                    state_n_s    = ST_FRAME;
                    frame_open_s = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (frame_fall_s) begin
                    state_n_s     = ST_IDLE;
                    close_frame_s = 1'b1;
                end else if (line_rise_s) begin
                    state_n_s    = ST_LINE;
                    line_start_s = 1'b1;
                end else begin
                    state_n_s = ST_FRAME;
                end
            end
            ST_LINE: begin
                if (frame_fall_s) begin
                    state_n_s     = ST_IDLE;
                    close_line_s  = 1'b1;
                    close_frame_s = 1'b1;
                end else if (line_fall_s) begin
                    state_n_s    = ST_FRAME;
                    close_line_s = 1'b1;
                end else begin
                    state_n_s = ST_LINE;
                    beat_s    = valid_lvl_s;
                end
            end
            default: begin
                state_n_s = ST_SYNC;
            end
        endcase
    end

    assign words_bad_s = close_line_s & (word_cnt_r != EXP_WORDS_C);
    assign lines_bad_s = close_frame_s & (line_cnt_r != EXP_LINES_C);

    // Counters, latched results and sticky errors; a new error event beats err_clr.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_cnt_r   <= CNT_ZERO;
            word_cnt_r   <= CNT_ZERO;
            last_lines_r <= CNT_ZERO;
            last_words_r <= CNT_ZERO;
            frame_cnt_r  <= CNT_ZERO;
            frame_done_r <= 1'b0;
            err_lines_r  <= 1'b0;
            err_words_r  <= 1'b0;
            err_proto_r  <= 1'b0;
        end else begin
            if (frame_open_s) begin
                line_cnt_r <= CNT_ZERO;
            end else if (line_start_s) begin
                line_cnt_r <= sat_inc(line_cnt_r);
            end else begin
                line_cnt_r <= line_cnt_r;
            end
            if (line_start_s) begin
                word_cnt_r <= CNT_ZERO;
            end else if (beat_s) begin
                word_cnt_r <= sat_inc(word_cnt_r);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
            if (close_line_s) begin
                last_words_r <= word_cnt_r;
            end else begin
                last_words_r <= last_words_r;
            end
            if (close_frame_s) begin
                last_lines_r <= line_cnt_r;
                frame_cnt_r  <= frame_cnt_r + CNT_ONE;
            end else begin
                last_lines_r <= last_lines_r;
                frame_cnt_r  <= frame_cnt_r;
            end
            frame_done_r <= close_frame_s;
            err_lines_r  <= lines_bad_s | (err_lines_r & ~err_clr);
            err_words_r  <= words_bad_s | (err_words_r & ~err_clr);
            err_proto_r  <= proto_err_s | (err_proto_r & ~err_clr);
        end
    end

    assign last_lines = last_lines_r;
    assign last_words = last_words_r;
    assign frame_cnt  = frame_cnt_r;
    assign frame_done = frame_done_r;
    assign err_lines  = err_lines_r;
    assign err_words  = err_words_r;
    assign err_proto  = err_proto_r;

`ifdef FRAME_MON_FPS_EN
    logic [7:0] win_r;
    logic [7:0] fps_r;

    // One-second window; a frame_done arriving with sec_tick belongs to the closing window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_r <= 8'd0;
            fps_r <= 8'd0;
        end else if (sec_tick) begin
            win_r <= 8'd0;
            fps_r <= sat_add8(win_r, frame_done_r);
        end else begin
            win_r <= sat_add8(win_r, frame_done_r);
            fps_r <= fps_r;
        end
    end

    assign fps = fps_r;
`else
    logic unused_sec_tick_s;
    assign unused_sec_tick_s = sec_tick;
    assign fps = 8'd0;
`endif

endmodule

// File: tb/tb_csi_frame_monitor.sv
// Self-checking bench for csi_frame_monitor: behavioural geometry model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_csi_frame_monitor;

    localparam int CNT_W = 16;
    localparam int EXP_L = 4;
    localparam int EXP_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, csi_in_frame, csi_in_line, csi_word_valid, sec_tick, err_clr;
    logic [CNT_W-1:0] last_lines, last_words, frame_cnt;
    logic [7:0] fps;
    logic frame_done, err_lines, err_words, err_proto;

    csi_frame_monitor #(.EXP_LINES(EXP_L), .EXP_WORDS(EXP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .csi_in_frame(csi_in_frame), .csi_in_line(csi_in_line), .csi_word_valid(csi_word_valid),
        .sec_tick(sec_tick), .err_clr(err_clr),
        .last_lines(last_lines), .last_words(last_words), .frame_cnt(frame_cnt), .fps(fps),
        .frame_done(frame_done), .err_lines(err_lines), .err_words(err_words), .err_proto(err_proto)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic [7:0] sat8(input int v);
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

    // Behavioural model: what a monitor observing the inputs (seen one cycle late) must report.
    bit m_synced = 1'b0, m_in_frame = 1'b0, m_in_line = 1'b0;
    int m_lines = 0, m_words = 0;
    logic [7:0] m_win = 8'd0, e_fps = 8'd0;
    logic [CNT_W-1:0] e_last_lines = '0, e_last_words = '0, e_frame_cnt = '0;
    logic e_done = 1'b0, e_err_l = 1'b0, e_err_w = 1'b0, e_err_p = 1'b0;
    logic qf = 1'b0, ql = 1'b0, qv = 1'b0, qqf = 1'b0, qql = 1'b0;

    always @(posedge clk) begin : model
        logic rf, ff, rl, fl, old_done, bad_w, bad_l, bad_p;
        if (!reset_n) begin
            m_synced = 1'b0; m_in_frame = 1'b0; m_in_line = 1'b0;
            m_lines = 0; m_words = 0; m_win = 8'd0; e_fps = 8'd0;
            e_last_lines = '0; e_last_words = '0; e_frame_cnt = '0;
            e_done = 1'b0; e_err_l = 1'b0; e_err_w = 1'b0; e_err_p = 1'b0;
            qf = csi_in_frame; qqf = csi_in_frame;
            ql = csi_in_line;  qql = csi_in_line;
            qv = csi_word_valid;
        end else begin
            rf = qf & ~qqf; ff = ~qf & qqf;
            rl = ql & ~qql; fl = ~ql & qql;
            old_done = e_done;
            e_done = 1'b0; bad_w = 1'b0; bad_l = 1'b0; bad_p = 1'b0;
            if (!m_synced) begin
                if (!qf) m_synced = 1'b1;
            end else if (m_in_frame) begin
                if (ff) begin
                    if (m_in_line) begin
                        e_last_words = m_words[CNT_W-1:0];
                        bad_w = (m_words != EXP_W);
                    end
                    e_last_lines = m_lines[CNT_W-1:0];
                    bad_l = (m_lines != EXP_L);
                    e_frame_cnt = e_frame_cnt + 1'b1;
                    e_done = 1'b1;
                    m_in_frame = 1'b0;
                    m_in_line = 1'b0;
                end else if (!m_in_line && rl) begin
                    m_in_line = 1'b1;
                    m_lines = sat16(m_lines + 1);
                    m_words = 0;
                end else if (m_in_line && fl) begin
                    e_last_words = m_words[CNT_W-1:0];
                    bad_w = (m_words != EXP_W);
                    m_in_line = 1'b0;
                end else if (m_in_line && qv) begin
                    m_words = sat16(m_words + 1);
                end
            end else begin
                bad_p = rl;
                if (rf) begin
                    m_in_frame = 1'b1;
                    m_lines = 0;
                end
            end
            e_err_w = bad_w | (e_err_w & ~err_clr);
            e_err_l = bad_l | (e_err_l & ~err_clr);
            e_err_p = bad_p | (e_err_p & ~err_clr);
`ifdef FRAME_MON_FPS_EN
            if (sec_tick) begin
                e_fps = sat8(int'(m_win) + int'(old_done));
                m_win = 8'd0;
            end else begin
                m_win = sat8(int'(m_win) + int'(old_done));
            end
`endif
            qqf = qf; qql = ql;
            qf = csi_in_frame; ql = csi_in_line; qv = csi_word_valid;
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        check("last_lines", 32'(last_lines), 32'(e_last_lines));
        check("last_words", 32'(last_words), 32'(e_last_words));
        check("frame_cnt",  32'(frame_cnt),  32'(e_frame_cnt));
        check("fps",        32'(fps),        32'(e_fps));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("err_lines",  32'(err_lines),  32'(e_err_l));
        check("err_words",  32'(err_words),  32'(e_err_w));
        check("err_proto",  32'(err_proto),  32'(e_err_p));
        if (frame_done === 1'b1) done_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_line(input int beats, input bit hold_line, input bit clr_at_fall);
        csi_in_line = 1'b1;
        tick(2);
        for (int b = 0; b < beats; b++) begin
            csi_word_valid = 1'b1;
            tick(1);
            if (b % 3 == 2) begin
                csi_word_valid = 1'b0;
                tick(1);
            end
        end
        csi_word_valid = 1'b0;
        tick(1);
        if (!hold_line) begin
            csi_in_line = 1'b0;
            if (clr_at_fall) begin
                tick(1);
                err_clr = 1'b1;
                tick(1);
                err_clr = 1'b0;
                tick(1);
            end else begin
                tick(3);
            end
        end
    endtask

    task automatic send_frame(input int nlines, input int short_idx, input int short_beats,
                              input bit joint_end, input bit tick_end, input int clr_idx);
        csi_in_frame = 1'b1;
        tick(2);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == short_idx) ? short_beats : EXP_W,
                      joint_end && (l == nlines - 1), l == clr_idx);
        end
        csi_in_frame = 1'b0;
        csi_in_line  = 1'b0;
        if (tick_end) begin
            tick(2);
            sec_tick = 1'b1;
            tick(1);
            sec_tick = 1'b0;
            tick(2);
        end else begin
            tick(3);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    task automatic pulse_sec();
        sec_tick = 1'b1;
        tick(1);
        sec_tick = 1'b0;
        tick(1);
    endtask

    initial begin
        int base;
        reset_n = 1'b0; csi_in_frame = 1'b0; csi_in_line = 1'b0;
        csi_word_valid = 1'b0; sec_tick = 1'b0; err_clr = 1'b0;
        tick(3);
        check("rst_last_lines", 32'(last_lines), 32'd0);
        check("rst_last_words", 32'(last_words), 32'd0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        check("rst_fps",        32'(fps),        32'd0);
        check("rst_errs", 32'({frame_done, err_lines, err_words, err_proto}), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Two clean frames.
        base = done_seen;
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        check("clean_last_lines", 32'(last_lines), 32'd4);
        check("clean_last_words", 32'(last_words), 32'd8);
        check("clean_frame_cnt",  32'(frame_cnt),  32'd2);
        check("clean_done_pulses", 32'(done_seen - base), 32'd2);
        check("clean_errs", 32'({err_lines, err_words, err_proto}), 32'd0);

        // Reset in the middle of line 2, released with the frame still high.
        csi_in_frame = 1'b1;
        tick(2);
        send_line(EXP_W, 1'b0, 1'b0);
        csi_in_line = 1'b1;
        tick(2);
        repeat (3) begin csi_word_valid = 1'b1; tick(1); end
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (5) begin csi_word_valid = 1'b1; tick(1); end
        csi_word_valid = 1'b0;
        tick(1);
        csi_in_line = 1'b0;
        tick(2);
        send_line(EXP_W, 1'b0, 1'b0);
        send_line(EXP_W, 1'b0, 1'b0);
        csi_in_frame = 1'b0;
        tick(3);
        check("partial_frame_cnt",  32'(frame_cnt),  32'd0);
        check("partial_last_lines", 32'(last_lines), 32'd0);
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        check("after_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        check("after_rst_errs", 32'({err_lines, err_words, err_proto}), 32'd0);

        // Short line and long frame; then err_clr racing a new word mismatch.
        send_frame(5, 2, 7, 1'b0, 1'b0, -1);
        check("mis_err_words",  32'(err_words),  32'd1);
        check("mis_err_lines",  32'(err_lines),  32'd1);
        check("mis_last_lines", 32'(last_lines), 32'd5);
        pulse_clr();
        check("clr_errs", 32'({err_lines, err_words}), 32'd0);
        send_frame(4, 1, 6, 1'b0, 1'b0, 1);
        check("clr_race_err_words", 32'(err_words), 32'd1);
        check("clr_race_err_lines", 32'(err_lines), 32'd0);

        // Line and frame fall together.
        base = done_seen;
        send_frame(4, 3, 5, 1'b1, 1'b0, -1);
        check("joint_last_words", 32'(last_words), 32'd5);
        check("joint_last_lines", 32'(last_lines), 32'd4);
        check("joint_done_pulses", 32'(done_seen - base), 32'd1);
        check("joint_frame_cnt", 32'(frame_cnt), 32'd4);

        // Line pulse outside any frame.
        pulse_clr();
        csi_in_line = 1'b1;
        tick(2);
        csi_in_line = 1'b0;
        tick(3);
        check("proto_err",        32'(err_proto),  32'd1);
        check("proto_last_lines", 32'(last_lines), 32'd4);
        check("proto_frame_cnt",  32'(frame_cnt),  32'd4);
        pulse_clr();

        // Frame rate window.
        pulse_sec();
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        send_frame(4, -1, 0, 1'b0, 1'b0, -1);
        pulse_sec();
`ifdef FRAME_MON_FPS_EN
        check("fps_three", 32'(fps), 32'd3);
`else
        check("fps_off_a", 32'(fps), 32'd0);
`endif
        send_frame(4, -1, 0, 1'b0, 1'b1, -1);
`ifdef FRAME_MON_FPS_EN
        check("fps_one", 32'(fps), 32'd1);
`else
        check("fps_off_b", 32'(fps), 32'd0);
`endif
        pulse_sec();
        check("fps_empty", 32'(fps), 32'd0);
        check("final_frame_cnt", 32'(frame_cnt), 32'd8);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
